// File: rtl/synth_pkg.sv
// Shared constants, note look-up table, FSM state type and the lowest-key
// helper used by the keyboard front-end of the synth voice.
package synth_pkg;

    localparam int NUM_KEYS      = 12;
    localparam int HALF_PERIOD_W = 8;
    localparam int KEY_IDX_W     = 4;

    // Half-period in 48 kHz samples for C4..B4, index = semitone above C4
    localparam logic [HALF_PERIOD_W-1:0] NOTE_HALF_PERIOD [NUM_KEYS] = '{
        8'd92, 8'd87, 8'd82, 8'd77, 8'd73, 8'd69,
        8'd65, 8'd61, 8'd58, 8'd55, 8'd51, 8'd49
    };

    typedef enum logic {IDLE, PLAYING} note_state_t;

    // Index of the lowest set bit; 0 when no bit is set
    function automatic logic [KEY_IDX_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
        logic [KEY_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) begin
                idx = KEY_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key input: two-flop synchroniser followed by a hold-time debouncer.
// The stable level only follows the synchronised input after it has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 12288
) (
    input  logic master_clk,
    input  logic reset,
    input  logic raw_key,
    output logic stable_key
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, count disagreement, accept on terminal count
    always_comb begin
        sync1_d  = raw_key;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_key = stable_q;

endmodule

// File: rtl/key_note_encoder.sv
// Keyboard front-end: debounces every key, detects presses and releases,
// and picks one active note (last press wins) together with its tone
// half-period, gate and a change pulse for the tone stage.
module key_note_encoder
    import synth_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 12288
) (
    input  logic                     master_clk,
    input  logic                     reset,
    input  logic [NUM_KEYS-1:0]      synth_keys,
    output logic [NUM_KEYS-1:0]      key_held,
    output logic [KEY_IDX_W-1:0]     key_index,
    output logic                     note_on,
    output logic                     note_event,
    output logic [HALF_PERIOD_W-1:0] tone_half_period
);

    logic [NUM_KEYS-1:0]      stable_keys;
    logic [NUM_KEYS-1:0]      press_vec;
    logic [NUM_KEYS-1:0]      release_vec;

    note_state_t              state_q, state_d;
    logic [NUM_KEYS-1:0]      key_held_q, key_held_d;
    logic [KEY_IDX_W-1:0]     key_index_q, key_index_d;
    logic                     note_on_q, note_on_d;
    logic                     note_event_q, note_event_d;
    logic [HALF_PERIOD_W-1:0] half_period_q, half_period_d;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .master_clk (master_clk),
            .reset      (reset),
            .raw_key    (synth_keys[g]),
            .stable_key (stable_keys[g])
        );
    end

    // Press/release detection against the previous stable levels held in key_held_q
    always_comb begin
        press_vec   = stable_keys & ~key_held_q;
        release_vec = ~stable_keys & key_held_q;
    end

    // Note selection FSM; any press outranks a release in the same cycle
    always_comb begin
        state_d       = state_q;
        key_held_d    = stable_keys;
        key_index_d   = key_index_q;
        note_on_d     = note_on_q;
        half_period_d = half_period_q;
        note_event_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|press_vec) begin
                    state_d     = PLAYING;
                    key_index_d = lowest_key(press_vec);
                    note_on_d   = 1'b1;
                end
            end
            PLAYING: begin
                if (|press_vec) begin
                    key_index_d = lowest_key(press_vec);
                end else if (stable_keys == '0) begin
                    state_d   = IDLE;
                    note_on_d = 1'b0;
                end else if (release_vec[key_index_q]) begin
                    key_index_d = lowest_key(stable_keys);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        half_period_d = NOTE_HALF_PERIOD[key_index_d];
        note_event_d  = (key_index_d != key_index_q) || (note_on_d != note_on_q);
    end

    // Output and state registers, cleared asynchronously to the C4 rest state
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            key_held_q    <= '0;
            key_index_q   <= '0;
            note_on_q     <= 1'b0;
            note_event_q  <= 1'b0;
            half_period_q <= NOTE_HALF_PERIOD[0];
        end else begin
            state_q       <= state_d;
            key_held_q    <= key_held_d;
            key_index_q   <= key_index_d;
            note_on_q     <= note_on_d;
            note_event_q  <= note_event_d;
            half_period_q <= half_period_d;
        end
    end

    assign key_held         = key_held_q;
    assign key_index        = key_index_q;
    assign note_on          = note_on_q;
    assign note_event       = note_event_q;
    assign tone_half_period = half_period_q;

endmodule
